// File: rtl/fetch_pc_gen_if.sv
// Fetch-side bus for fetch_pc_gen: predictor lookup, fetch request handshake,
// execute redirect and branch-resolution training stream.
interface fetch_pc_gen_if;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        is_br;
        logic        taken;
    } IUpdatePredictionIO;

    logic [31:0]        lookup_pc;
    logic               pred_taken;
    logic               req_valid;
    logic               req_ready;
    logic [31:0]        req_pc;
    logic               req_pred_taken;
    logic [31:0]        req_pred_target;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    IUpdatePredictionIO updateio;
    logic [31:0]        update_target;

    modport master (
        output lookup_pc, req_valid, req_pc, req_pred_taken, req_pred_target,
        input  pred_taken, req_ready, redirect_valid, redirect_pc,
               updateio, update_target
    );

    modport slave (
        input  lookup_pc, req_valid, req_pc, req_pred_taken, req_pred_target,
        output pred_taken, req_ready, redirect_valid, redirect_pc,
               updateio, update_target
    );

endinterface

// File: rtl/fetch_pc_gen.sv
// Next-PC generator: owns the fetch PC, combines the direction predictor with a
// direct-mapped BTB, and issues fetch requests over a valid/ready handshake.
module fetch_pc_gen #(
    parameter int          ADDR_WIDTH = 6,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    fetch_pc_gen_if.master bus
);

    typedef enum logic [1:0] {IDLE, RUN, STALL, BUBBLE} state_e;

    localparam int ENTRIES = 2 ** ADDR_WIDTH;
    localparam int TAG_W   = 30 - ADDR_WIDTH;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        heldTaken_q, heldTaken_d;
    logic [31:0] heldTarget_q, heldTarget_d;

    logic [ENTRIES-1:0] btbValid_q;
    logic [TAG_W-1:0]   btbTag_q    [ENTRIES];
    logic [31:0]        btbTarget_q [ENTRIES];

    logic [ADDR_WIDTH-1:0] lookupIdx, updIdx;
    logic [TAG_W-1:0]      lookupTag, updTag;
    logic                  hit, predTaken;
    logic [31:0]           predTarget, redirectPc;
    logic                  reqValid, outTaken;
    logic [31:0]           outTarget;
    logic                  unusedBits;

    assign lookupIdx  = pc_q[ADDR_WIDTH+1:2];
    assign lookupTag  = pc_q[31:ADDR_WIDTH+2];
    assign updIdx     = bus.updateio.pc[ADDR_WIDTH+1:2];
    assign updTag     = bus.updateio.pc[31:ADDR_WIDTH+2];
    assign redirectPc = {bus.redirect_pc[31:2], 2'b00};
    assign unusedBits = ^{bus.redirect_pc[1:0], bus.updateio.pc[1:0]};

    assign hit        = btbValid_q[lookupIdx] && (btbTag_q[lookupIdx] == lookupTag);
    assign predTaken  = hit && bus.pred_taken;
    assign predTarget = predTaken ? btbTarget_q[lookupIdx] : pc_q + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            heldTaken_q  <= 1'b0;
            heldTarget_q <= RESET_PC + 32'd4;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            heldTaken_q  <= heldTaken_d;
            heldTarget_q <= heldTarget_d;
        end
    end

    // Redirect always wins over the handshake and kills the request in the same cycle.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        heldTaken_d  = heldTaken_q;
        heldTarget_d = heldTarget_q;
        reqValid     = 1'b0;
        outTaken     = predTaken;
        outTarget    = predTarget;
        case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                reqValid = !bus.redirect_valid;
                if (bus.redirect_valid) begin
                    pc_d    = redirectPc;
                    state_d = BUBBLE;
                end else if (bus.req_ready) begin
                    pc_d = predTarget;
                end else begin
                    heldTaken_d  = predTaken;
                    heldTarget_d = predTarget;
                    state_d      = STALL;
                end
            end
            STALL: begin
                reqValid  = !bus.redirect_valid;
                outTaken  = heldTaken_q;
                outTarget = heldTarget_q;
                if (bus.redirect_valid) begin
                    pc_d    = redirectPc;
                    state_d = BUBBLE;
                end else if (bus.req_ready) begin
                    pc_d    = heldTarget_q;
                    state_d = RUN;
                end
            end
            BUBBLE: begin
                if (bus.redirect_valid) begin
                    pc_d = redirectPc;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.lookup_pc       = pc_q;
    assign bus.req_pc          = pc_q;
    assign bus.req_valid       = reqValid;
    assign bus.req_pred_taken  = outTaken;
    assign bus.req_pred_target = outTarget;

    // Non-branch resolutions evict only an entry whose tag they actually alias.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btbValid_q <= '0;
        end else if (bus.updateio.valid) begin
            if (bus.updateio.is_br && bus.updateio.taken) begin
                btbValid_q[updIdx] <= 1'b1;
            end else if (!bus.updateio.is_br && (btbTag_q[updIdx] == updTag)) begin
                btbValid_q[updIdx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.updateio.valid && bus.updateio.is_br && bus.updateio.taken) begin
            btbTag_q[updIdx]    <= updTag;
            btbTarget_q[updIdx] <= bus.update_target;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: accepted requests are checked by a scoreboard
// monitor; reset, stall-hold and redirect behaviour are checked directly.
module tb_fetch_pc_gen;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } expTxn_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    expTxn_t sbQueue[$];

    fetch_pc_gen_if bus ();

    fetch_pc_gen #(
        .ADDR_WIDTH(6),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic setUpdate(input logic [31:0] pc, input logic isBr, input logic taken,
                             input logic [31:0] target);
        bus.updateio.valid = 1'b1;
        bus.updateio.pc    = pc;
        bus.updateio.is_br = isBr;
        bus.updateio.taken = taken;
        bus.update_target  = target;
    endtask

    // One cycle of stimulus: drives inputs, pushes the expected accepted request,
    // checks req_valid, then advances past the next rising edge.
    task automatic applyStimulus(input logic ready, input logic predTaken,
                                 input logic redirect, input logic [31:0] redirectPc,
                                 input logic expValid, input logic [31:0] expPc,
                                 input logic expTaken, input logic [31:0] expTarget);
        expTxn_t t;
        bus.req_ready      = ready;
        bus.pred_taken     = predTaken;
        bus.redirect_valid = redirect;
        bus.redirect_pc    = redirectPc;
        if (ready && expValid) begin
            t.pc     = expPc;
            t.taken  = expTaken;
            t.target = expTarget;
            sbQueue.push_back(t);
        end
        #2;
        checkOutput("req_valid", {31'd0, bus.req_valid}, {31'd0, expValid});
        @(posedge clk);
        #1;
        bus.updateio.valid = 1'b0;
        bus.redirect_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && bus.req_valid && bus.req_ready) begin
            checks++;
            if (sbQueue.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_req: got pc 0x%08h with empty scoreboard",
                         bus.req_pc);
            end else begin
                expTxn_t e;
                e = sbQueue.pop_front();
                if (bus.req_pc !== e.pc || bus.req_pred_taken !== e.taken ||
                    bus.req_pred_target !== e.target) begin
                    errors++;
                    $display("[TB] FAIL req_txn: got pc 0x%08h taken %0b target 0x%08h expected pc 0x%08h taken %0b target 0x%08h",
                             bus.req_pc, bus.req_pred_taken, bus.req_pred_target,
                             e.pc, e.taken, e.target);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.pred_taken     = 1'b0;
        bus.req_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.updateio       = '0;
        bus.update_target  = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req_valid", {31'd0, bus.req_valid}, 32'd0);
        checkOutput("rst_req_pc", bus.req_pc, 32'h0);
        checkOutput("rst_lookup_pc", bus.lookup_pc, 32'h0);
        checkOutput("rst_pred_taken", {31'd0, bus.req_pred_taken}, 32'd0);
        checkOutput("rst_pred_target", bus.req_pred_target, 32'h4);
        reset = 1'b0;

        // Sequential fetch from an empty BTB
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 32'h0, 0, 32'h4);
        applyStimulus(1, 0, 0, 0, 1, 32'h4, 0, 32'h8);
        applyStimulus(1, 0, 0, 0, 1, 32'h8, 0, 32'hC);
        applyStimulus(1, 0, 0, 0, 1, 32'hC, 0, 32'h10);

        // Training write in the same cycle as the lookup of 0x10 sees the old entry
        setUpdate(32'h10, 1, 1, 32'h80);
        applyStimulus(1, 1, 0, 0, 1, 32'h10, 0, 32'h14);
        applyStimulus(1, 0, 1, 32'h10, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 32'h10, 1, 32'h80);
        applyStimulus(1, 0, 0, 0, 1, 32'h80, 0, 32'h84);
        applyStimulus(1, 0, 1, 32'h10, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 32'h10, 0, 32'h14);

        // Stall on a hit; retraining and predictor toggles must not disturb the held request
        applyStimulus(1, 0, 1, 32'h10, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0);
        setUpdate(32'h10, 1, 1, 32'h90);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        checkOutput("stall_req_pc", bus.req_pc, 32'h10);
        checkOutput("stall_pred_taken", {31'd0, bus.req_pred_taken}, 32'd1);
        checkOutput("stall_pred_target", bus.req_pred_target, 32'h80);
        applyStimulus(1, 0, 0, 0, 1, 32'h10, 1, 32'h80);

        // Redirect during a stall, low address bits dropped
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 32'h203, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 32'h200, 0, 32'h204);

        // Non-branch update with a different tag leaves the entry alone
        setUpdate(32'h110, 0, 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 1, 32'h204, 0, 32'h208);
        applyStimulus(1, 0, 1, 32'h10, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 32'h10, 1, 32'h90);

        // Non-branch update with a matching tag evicts it
        setUpdate(32'h10, 0, 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 1, 32'h90, 0, 32'h94);
        applyStimulus(1, 0, 1, 32'h10, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 32'h10, 0, 32'h14);

        // PC wrap-around at the top of the address space
        applyStimulus(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 1, 32'h0, 0, 32'h4);

        // Reset asserted in the middle of a stall
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
        reset = 1'b1;
        #1;
        checkOutput("midrst_req_valid", {31'd0, bus.req_valid}, 32'd0);
        checkOutput("midrst_req_pc", bus.req_pc, 32'h0);
        checkOutput("midrst_lookup_pc", bus.lookup_pc, 32'h0);
        checkOutput("midrst_pred_taken", {31'd0, bus.req_pred_taken}, 32'd0);
        checkOutput("midrst_pred_target", bus.req_pred_target, 32'h4);

        checkOutput("sb_leftover", sbQueue.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
